// File: rtl/fetch_mode_ctrl.sv
// Fetch-region controller: tracks NORMAL/SWI/EXC/HWI/HALT and forms the physical fetch
// address from the region (mode) and the core's offset, with single-cycle PC redirects.
module fetch_mode_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pc_in,
  input  logic       swi_req,
  input  logic       exc_req,
  input  logic       hwi_req,
  input  logic       iret,
  output logic [5:0] phys_addr,
  output logic [1:0] mode,
  output logic       pc_load,
  output logic [3:0] pc_load_val,
  output logic       hwi_ack,
  output logic       swi_drop,
  output logic       fault
);

  typedef enum logic [2:0] {NORMAL, SWI, EXC, HWI, HALT} state_t;

  state_t     state;
  logic [3:0] saved_pc;

  // Region bits never take a carry from the offset: the 4-bit offset wraps in place.
  assign phys_addr = {mode, pc_load ? pc_load_val : pc_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= NORMAL;
      mode        <= 2'b00;
      saved_pc    <= '0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      hwi_ack     <= 1'b0;
      swi_drop    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      hwi_ack     <= 1'b0;
      swi_drop    <= 1'b0;
      case (state)
        NORMAL: begin
          if (exc_req || hwi_req || swi_req) begin
            saved_pc <= pc_in;
            pc_load  <= 1'b1;
            if (exc_req) begin
              state <= EXC;
              mode  <= 2'b10;
            end else if (hwi_req) begin
              state   <= HWI;
              mode    <= 2'b11;
              hwi_ack <= 1'b1;
            end else begin
              state <= SWI;
              mode  <= 2'b01;
            end
          end
        end
        SWI, EXC, HWI: begin
          // Handlers never nest: a new SWI is reported as dropped, HWI stays pending.
          swi_drop <= swi_req;
          if (exc_req) begin
            state <= HALT;
            mode  <= 2'b10;
            fault <= 1'b1;
          end else if (iret) begin
            state       <= NORMAL;
            mode        <= 2'b00;
            pc_load     <= 1'b1;
            pc_load_val <= saved_pc;
          end
        end
        HALT: begin
          mode  <= 2'b10;
          fault <= 1'b1;
        end
        default: begin
          state <= NORMAL;
          mode  <= 2'b00;
        end
      endcase
    end
  end

endmodule
